imem_loader: RTL and testbench

Instruction-memory front end for the single-cycle CPU. It sits directly upstream of the CPU's instruction port. It receives a program as a byte stream over a valid/ready handshake and writes it into an internal word RAM. It then releases the CPU from reset and serves `IM_inst` combinationally from the CPU's `PC_out`. While loading, the CPU is held in reset with `ena` deasserted.

---
 rtl/imem_loader.sv | 191 +++++++++++++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader and combinational instruction ROM front end; optional checksum via IMEM_LOADER_CKSUM_EN
module imem_loader #(
  parameter int unsigned DEPTH_LOG2 = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        cpu_rst,
  output logic        cpu_ena,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] DEPTH = 32'd1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CKSUM,
    S_RUN,
    S_ERR
  } state_t;

  // State entered once the last data word (or an empty program) has arrived
`ifdef IMEM_LOADER_CKSUM_EN
  localparam state_t S_TAIL = S_CKSUM;
`else
  localparam state_t S_TAIL = S_RUN;
`endif

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] widx_q,  widx_d;
  logic [1:0]  bcnt_q,  bcnt_d;
  logic [23:0] word_q,  word_d;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        accept;

  logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]  cksum_q, cksum_d;
`endif

  assign accept    = in_ready && in_valid;
  assign mem_wdata = {in_byte, word_q};

  // Control outputs decoded purely from the registered state
  always_comb begin
    in_ready = 1'b0;
    cpu_rst  = 1'b1;
    cpu_ena  = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_LEN, S_DATA, S_CKSUM: in_ready = 1'b1;
      S_RUN: begin
        cpu_rst = 1'b0;
        cpu_ena = 1'b1;
        done    = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Next-state, word assembly and RAM write strobe
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    mem_we  = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    cksum_d = cksum_q;
`endif
    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          count_d = '0;
          widx_d  = '0;
          bcnt_d  = '0;
          word_d  = '0;
`ifdef IMEM_LOADER_CKSUM_EN
          cksum_d = '0;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
          if (!bcnt_q[0]) begin
            count_d[7:0] = in_byte;
            bcnt_d       = 2'd1;
          end else begin
            count_d = {in_byte, count_q[7:0]};
            bcnt_d  = 2'd0;
            if (count_d == 16'd0) begin
              state_d = S_TAIL;
            end else if ({16'd0, count_d} > DEPTH) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          // Bytes enter at the top and shift down, so byte 0 ends in [7:0]
          word_d = {in_byte, word_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ in_byte;
`endif
          if (bcnt_q == 2'd3) begin
            mem_we = 1'b1;
            widx_d = widx_q + 16'd1;
            if (widx_d == count_q) begin
              state_d = S_TAIL;
            end
          end
        end
      end
      S_CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
        if (accept) begin
          state_d = (in_byte == cksum_q) ? S_RUN : S_ERR;
        end
`else
        state_d = S_RUN;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and load-progress registers; reset abandons any partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  // Program RAM write port; contents survive reset and reloads
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[widx_q[DEPTH_LOG2-1:0]] <= mem_wdata;
    end
  end

  // Word offset of pc from the text base, computed modulo 2^32 without the byte lane
  logic [29:0] woff;
  logic        lane_borrow;
  assign lane_borrow = (pc[1:0] < BASE_ADDR[1:0]);
  assign woff        = pc[31:2] - BASE_ADDR[31:2] - {29'd0, lane_borrow};

  // Combinational fetch; anything outside the RAM window reads as a nop
  always_comb begin
    inst = 32'd0;
    if (woff[29:DEPTH_LOG2] == '0) begin
      inst = mem[woff[DEPTH_LOG2-1:0]];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        cpu_rst;
  logic        cpu_ena;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_cnt = 0;
  int t0, rdy0, nb;

  logic [7:0] stream1[$];
  logic [7:0] stream2[$];
  logic [7:0] partial[$];
  logic [7:0] bad_len[$];
  logic [7:0] empty[$];

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .pc       (pc),
    .inst     (inst),
    .cpu_rst  (cpu_rst),
    .cpu_ena  (cpu_ena),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_ready) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0   = cyc;
    rdy0 = rdy_cnt;
  endtask

  task automatic push(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    if (gap) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rdy_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] bs[$], input bit gap);
    foreach (bs[i]) push(bs[i], gap);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    chk(tag, inst, exp);
  endtask

  initial begin
    stream1 = '{8'h02, 8'h00, 8'h08, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    stream2 = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    partial = '{8'h02, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    bad_len = '{8'h00, 8'h10};
    empty   = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CKSUM_EN
    stream1.push_back(8'h28);
    stream2.push_back(8'h88);
    empty.push_back(8'h00);
`endif
    nb = stream1.size();

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; pc = BASE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("rst_cpu_ena",  32'(cpu_ena),  32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);

    // Back-to-back load
    pulse_start();
    send(stream1, 1'b0);
    chk("b2b_cycles",  32'(cyc - t0), 32'(nb));
    chk("b2b_done",    32'(done),     32'd1);
    chk("b2b_cpu_ena", 32'(cpu_ena),  32'd1);
    chk("b2b_cpu_rst", 32'(cpu_rst),  32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_ready_cycles", 32'(rdy_cnt - rdy0), 32'(nb));
    rd("b2b_w0", BASE,          32'h2000_0008);
    rd("b2b_w1", BASE + 32'd4,  32'h0000_0000);

    // Restart from RUN puts the CPU back in reset next cycle
    pulse_start();
    chk("restart_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("restart_cpu_ena",  32'(cpu_ena),  32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    rd("below_base", 32'h0000_0000, 32'h0000_0000);

    // Same stream with valid toggling
    send(stream1, 1'b1);
    chk("gap_cycles", 32'(cyc - t0), 32'(2 * nb));
    chk("gap_done",   32'(done),     32'd1);
    rd("gap_w0", BASE,         32'h2000_0008);
    rd("gap_w1", BASE + 32'd4, 32'h0000_0000);

    // Reset mid-load keeps completed words only
    pulse_start();
    send(stream2, 1'b0);
    rd("ld2_w0", BASE,         32'h1122_3344);
    rd("ld2_w1", BASE + 32'd4, 32'h5566_7788);
    pulse_start();
    send(partial, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("abort_done",     32'(done),     32'd0);
    rst = 1'b0;
    rd("abort_w0", BASE,         32'hAABB_CCDD);
    rd("abort_w1", BASE + 32'd4, 32'h5566_7788);
    rd("lane_ignored", BASE + 32'd6, 32'h5566_7788);
    rd("above_top", BASE + 32'd8192, 32'h0000_0000);

    // Oversized count goes to ERR; start recovers
    pulse_start();
    send(bad_len, 1'b0);
    chk("err_flag",     32'(err),      32'd1);
    chk("err_cpu_ena",  32'(cpu_ena),  32'd0);
    chk("err_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("err_in_ready", 32'(in_ready), 32'd0);
    pulse_start();
    chk("err_restart_ready", 32'(in_ready), 32'd1);
    chk("err_restart_err",   32'(err),      32'd0);

    // Empty program runs immediately
    send(empty, 1'b0);
    chk("empty_done", 32'(done), 32'd1);
    rd("empty_keeps_w0", BASE, 32'hAABB_CCDD);

`ifdef IMEM_LOADER_CKSUM_EN
    // Bad checksum byte
    pulse_start();
    stream1[nb-1] = 8'h29;
    send(stream1, 1'b0);
    chk("cks_err",     32'(err),     32'd1);
    chk("cks_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("cks_done",    32'(done),    32'd0);
    rd("cks_ram_kept", BASE, 32'h2000_0008);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
